// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared TLB widths and search requester ids
package tlb_pkg;
  localparam int TLBNUM = 16;
  localparam int IDXW   = $clog2(TLBNUM);
  localparam int VPN2_W = 19;
  localparam int PFN_W  = 20;
  localparam int ASID_W = 8;

  // Requester ids double as bit positions in the one-hot grant/rsel vectors.
  localparam int REQ_I = 0;
  localparam int REQ_D = 1;
  localparam int REQ_P = 2;
endpackage

// File: rtl/tlb_prio_sel.sv
// rtl/tlb_prio_sel.sv - 3-way fixed priority (p > d > i) with fetch starvation override
module tlb_prio_sel
  import tlb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic       starve_hit_i,
  input  logic       block_i,
  output logic [2:0] gnt_o
);

  always_comb begin
    gnt_o = 3'b000;
    if (!block_i) begin
      if (starve_hit_i && req_i[REQ_I]) gnt_o[REQ_I] = 1'b1;
      else if (req_i[REQ_P])            gnt_o[REQ_P] = 1'b1;
      else if (req_i[REQ_D])            gnt_o[REQ_D] = 1'b1;
      else if (req_i[REQ_I])            gnt_o[REQ_I] = 1'b1;
    end
  end

endmodule

// File: rtl/tlb_search_arb.sv
// rtl/tlb_search_arb.sv - shares the TLB search port between fetch, data and TLBP
// with a registered one-cycle response and a fetch anti-starvation counter.
module tlb_search_arb
  import tlb_pkg::*;
#(
  parameter int TLBNUM = tlb_pkg::TLBNUM,
  parameter int IDXW   = $clog2(TLBNUM),
  parameter int STARVE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_i,
  input  logic              d_req_i,
  input  logic              p_req_i,
  input  logic [VPN2_W-1:0] i_vpn2_i,
  input  logic [VPN2_W-1:0] d_vpn2_i,
  input  logic [VPN2_W-1:0] p_vpn2_i,
  input  logic              i_odd_i,
  input  logic              d_odd_i,
  output logic              i_gnt_o,
  output logic              d_gnt_o,
  output logic              p_gnt_o,
  output logic              i_rvalid_o,
  output logic              d_rvalid_o,
  output logic              p_rvalid_o,
  output logic              r_found_o,
  output logic [IDXW-1:0]   r_index_o,
  output logic [PFN_W-1:0]  r_pfn_o,
  output logic [2:0]        r_c_o,
  output logic              r_d_o,
  output logic              r_v_o,
  input  logic [ASID_W-1:0] asid_i,
  input  logic              tlbwi_we_i,
  input  logic              flush_i,
  output logic [VPN2_W-1:0] s_vpn2_o,
  output logic              s_odd_o,
  output logic [ASID_W-1:0] s_asid_o,
  input  logic              s_found_i,
  input  logic [IDXW-1:0]   s_index_i,
  input  logic [PFN_W-1:0]  s_pfn_i,
  input  logic [2:0]        s_c_i,
  input  logic              s_d_i,
  input  logic              s_v_i
);

  localparam int SCW = (STARVE > 2) ? $clog2(STARVE) : 1;
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE - 1);

  logic [2:0]       req;
  logic [2:0]       gnt;
  logic [SCW-1:0]   starve_cnt_q, starve_cnt_d;
  logic [2:0]       rsel_q;
  logic             found_q;
  logic [IDXW-1:0]  index_q;
  logic [PFN_W-1:0] pfn_q;
  logic [2:0]       c_q;
  logic             d_q;
  logic             v_q;

  // A write-back flush cancels fetch/data but TLBP is already past the flush point.
  always_comb begin
    req        = 3'b000;
    req[REQ_I] = i_req_i & ~flush_i;
    req[REQ_D] = d_req_i & ~flush_i;
    req[REQ_P] = p_req_i;
  end

  tlb_prio_sel u_prio_sel (
    .req_i        (req),
    .starve_hit_i (starve_cnt_q == STARVE_MAX),
    .block_i      (tlbwi_we_i | reset),
    .gnt_o        (gnt)
  );

  assign i_gnt_o = gnt[REQ_I];
  assign d_gnt_o = gnt[REQ_D];
  assign p_gnt_o = gnt[REQ_P];

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!i_req_i || gnt[REQ_I])        starve_cnt_d = '0;
    else if (starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + SCW'(1);
  end

  // Idle cycles steer the port to fetch; the result is simply not captured.
  always_comb begin
    s_vpn2_o = i_vpn2_i;
    s_odd_o  = i_odd_i;
    if (gnt[REQ_P]) begin
      s_vpn2_o = p_vpn2_i;
      s_odd_o  = 1'b0;
    end else if (gnt[REQ_D]) begin
      s_vpn2_o = d_vpn2_i;
      s_odd_o  = d_odd_i;
    end
  end

  assign s_asid_o = asid_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      rsel_q       <= 3'b000;
      found_q      <= 1'b0;
      index_q      <= '0;
      pfn_q        <= '0;
      c_q          <= 3'b000;
      d_q          <= 1'b0;
      v_q          <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsel_q       <= gnt;
      if (|gnt) begin
        found_q <= s_found_i;
        index_q <= s_index_i;
        pfn_q   <= s_pfn_i;
        c_q     <= s_c_i;
        d_q     <= s_d_i;
        v_q     <= s_v_i;
      end
    end
  end

  assign i_rvalid_o = rsel_q[REQ_I] & ~flush_i & ~reset;
  assign d_rvalid_o = rsel_q[REQ_D] & ~flush_i & ~reset;
  assign p_rvalid_o = rsel_q[REQ_P] & ~reset;

  assign r_found_o = found_q;
  assign r_index_o = index_q;
  assign r_pfn_o   = pfn_q;
  assign r_c_o     = c_q;
  assign r_d_o     = d_q;
  assign r_v_o     = v_q;

endmodule

// File: tb/tb_tlb_search_arb.sv
// tb/tb_tlb_search_arb.sv - scoreboard bench for tlb_search_arb with a behavioural TLB array
module tb_tlb_search_arb;
  import tlb_pkg::*;

  typedef struct packed {
    logic        found;
    logic [3:0]  index;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } res_t;

  typedef struct {
    int   id;
    bit   vis;
    int   due;
    res_t r;
  } exp_t;

  logic clk, reset;
  logic i_req, d_req, p_req, i_odd, d_odd;
  logic [18:0] i_vpn2, d_vpn2, p_vpn2;
  logic i_gnt, d_gnt, p_gnt, i_rvalid, d_rvalid, p_rvalid;
  logic r_found, r_d, r_v;
  logic [3:0] r_index;
  logic [19:0] r_pfn;
  logic [2:0] r_c;
  logic [7:0] asid, s_asid;
  logic tlbwi_we, flush;
  logic [18:0] s_vpn2;
  logic s_odd;
  res_t tlb_res;

  logic [18:0] e_vpn2 [16];
  logic [7:0]  e_asid [16];
  logic        e_g    [16];
  logic [25:0] e_pg   [16][2];

  exp_t sbq[$];
  int cyc, checks, errors;

  tlb_search_arb dut (
    .clk(clk), .reset(reset),
    .i_req_i(i_req), .d_req_i(d_req), .p_req_i(p_req),
    .i_vpn2_i(i_vpn2), .d_vpn2_i(d_vpn2), .p_vpn2_i(p_vpn2),
    .i_odd_i(i_odd), .d_odd_i(d_odd),
    .i_gnt_o(i_gnt), .d_gnt_o(d_gnt), .p_gnt_o(p_gnt),
    .i_rvalid_o(i_rvalid), .d_rvalid_o(d_rvalid), .p_rvalid_o(p_rvalid),
    .r_found_o(r_found), .r_index_o(r_index), .r_pfn_o(r_pfn),
    .r_c_o(r_c), .r_d_o(r_d), .r_v_o(r_v),
    .asid_i(asid), .tlbwi_we_i(tlbwi_we), .flush_i(flush),
    .s_vpn2_o(s_vpn2), .s_odd_o(s_odd), .s_asid_o(s_asid),
    .s_found_i(tlb_res.found), .s_index_i(tlb_res.index), .s_pfn_i(tlb_res.pfn),
    .s_c_i(tlb_res.c), .s_d_i(tlb_res.d), .s_v_i(tlb_res.v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t lookup(input logic [18:0] vpn2, input logic odd, input logic [7:0] a);
    res_t r;
    r = '0;
    for (int k = 15; k >= 0; k--) begin
      if (e_vpn2[k] == vpn2 && (e_g[k] || e_asid[k] == a)) begin
        r.found = 1'b1;
        r.index = 4'(k);
        {r.pfn, r.c, r.d, r.v} = e_pg[k][odd];
      end
    end
    return r;
  endfunction

  always_comb tlb_res = lookup(s_vpn2, s_odd, s_asid);

  task automatic half();
    logic [2:0] rv, ev;
    res_t got;
    exp_t e;
    @(negedge clk);
    rv  = {p_rvalid, d_rvalid, i_rvalid};
    got = {r_found, r_index, r_pfn, r_c, r_d, r_v};
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      e = sbq.pop_front();
      checks++; errors++;
      $display("FAIL sb_missed id %0d due %0d now %0d", e.id, e.due, cyc);
    end
    checks++;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e  = sbq.pop_front();
      ev = e.vis ? (3'b001 << e.id) : 3'b000;
      if (rv !== ev || got !== e.r) begin
        errors++;
        $display("FAIL sb_resp cyc %0d rvalid %b exp %b resp %h exp %h", cyc, rv, ev, got, e.r);
      end
    end else if (rv !== 3'b000) begin
      errors++;
      $display("FAIL sb_spurious cyc %0d rvalid %b exp 000", cyc, rv);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input int id, input bit vis);
    exp_t e;
    logic [18:0] v;
    logic o;
    case (id)
      REQ_I:   begin v = i_vpn2; o = i_odd; end
      REQ_D:   begin v = d_vpn2; o = d_odd; end
      default: begin v = p_vpn2; o = 1'b0;  end
    endcase
    e.id = id; e.vis = vis; e.due = cyc + 1; e.r = lookup(v, o, asid);
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    logic [2:0] g;
    reset = 1'b1;
    next(); next();
    i_req = 1'b1; p_req = 1'b1;
    half();
    g = {p_gnt, d_gnt, i_gnt};
    checks++;
    if (g !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b exp 000", g); end
    checks++;
    if ({r_found, r_index, r_pfn, r_c, r_d, r_v} !== 30'd0) begin
      errors++; $display("FAIL reset_resp got %h exp 0", {r_found, r_index, r_pfn, r_c, r_d, r_v});
    end
    checks++;
    if (dut.starve_cnt_q !== 2'd0) begin errors++; $display("FAIL reset_starve got %0d exp 0", dut.starve_cnt_q); end
    checks++;
    if (s_asid !== 8'h05) begin errors++; $display("FAIL s_asid got %h exp 05", s_asid); end
    next();
    reset = 1'b0; i_req = 1'b0; p_req = 1'b0;
  endtask

  task automatic test_single();
    logic [2:0] g;
    i_req = 1'b1; i_vpn2 = 19'h00010; i_odd = 1'b1;
    half();
    g = {p_gnt, d_gnt, i_gnt};
    checks++;
    if (g !== 3'b001 || s_vpn2 !== 19'h00010 || s_odd !== 1'b1) begin
      errors++; $display("FAIL single_gnt got %b vpn2 %h odd %b exp 001 00010 1", g, s_vpn2, s_odd);
    end
    push(REQ_I, 1'b1);
    next();
    i_req = 1'b0;
    half();
    checks++;
    if (r_found !== 1'b1 || r_index !== 4'd5 || r_pfn !== 20'h2000B) begin
      errors++; $display("FAIL single_resp got %b %0d %h exp 1 5 2000B", r_found, r_index, r_pfn);
    end
    next();
    // ASID mismatch on a non-global entry must miss
    asid = 8'h06; i_req = 1'b1; i_vpn2 = 19'h00103; i_odd = 1'b0;
    half();
    push(REQ_I, 1'b1);
    next();
    i_req = 1'b0; asid = 8'h05;
    half();
    checks++;
    if (r_found !== 1'b0) begin errors++; $display("FAIL miss_found got %b exp 0", r_found); end
    next();
  endtask

  task automatic test_all_three();
    logic [2:0] g;
    logic [2:0] exp_g [3] = '{3'b100, 3'b010, 3'b001};
    int gid [3] = '{REQ_P, REQ_D, REQ_I};
    i_req = 1'b1; i_vpn2 = 19'h00010; i_odd = 1'b0;
    d_req = 1'b1; d_vpn2 = 19'h00103; d_odd = 1'b1;
    p_req = 1'b1; p_vpn2 = 19'h00107;
    for (int t = 0; t < 3; t++) begin
      half();
      g = {p_gnt, d_gnt, i_gnt};
      checks++;
      if (g !== exp_g[t]) begin errors++; $display("FAIL all3_gnt t %0d got %b exp %b", t, g, exp_g[t]); end
      push(gid[t], 1'b1);
      next();
      case (gid[t])
        REQ_P:   p_req = 1'b0;
        REQ_D:   d_req = 1'b0;
        default: i_req = 1'b0;
      endcase
    end
    half();
    next();
  endtask

  task automatic test_starve();
    logic [2:0] g;
    logic [2:0] exp_g [4] = '{3'b010, 3'b010, 3'b001, 3'b010};
    int exp_cnt [4] = '{0, 1, 2, 0};
    int gid [4] = '{REQ_D, REQ_D, REQ_I, REQ_D};
    i_req = 1'b1; i_vpn2 = 19'h00010; i_odd = 1'b0;
    d_req = 1'b1; d_odd = 1'b0;
    for (int t = 0; t < 4; t++) begin
      d_vpn2 = 19'h00100 + 19'(t);
      half();
      g = {p_gnt, d_gnt, i_gnt};
      checks++;
      if (g !== exp_g[t] || int'(dut.starve_cnt_q) != exp_cnt[t]) begin
        errors++;
        $display("FAIL starve t %0d gnt %b cnt %0d exp %b %0d", t, g, dut.starve_cnt_q, exp_g[t], exp_cnt[t]);
      end
      push(gid[t], 1'b1);
      next();
      if (t == 2) i_req = 1'b0;
    end
    d_req = 1'b0;
    half();
    next();
  endtask

  task automatic test_tlbwi();
    logic [2:0] g;
    d_req = 1'b1; d_vpn2 = 19'h00120; d_odd = 1'b0; tlbwi_we = 1'b1;
    half();
    g = {p_gnt, d_gnt, i_gnt};
    checks++;
    if (g !== 3'b000) begin errors++; $display("FAIL tlbwi_block got %b exp 000", g); end
    @(posedge clk);
    e_vpn2[9] = 19'h00120; e_asid[9] = 8'h05; e_g[9] = 1'b0;
    e_pg[9][0] = {20'hABCDE, 3'd3, 1'b1, 1'b1};
    #1;
    cyc++;
    tlbwi_we = 1'b0;
    half();
    g = {p_gnt, d_gnt, i_gnt};
    checks++;
    if (g !== 3'b010) begin errors++; $display("FAIL tlbwi_regnt got %b exp 010", g); end
    push(REQ_D, 1'b1);
    next();
    d_req = 1'b0;
    half();
    checks++;
    if (r_found !== 1'b1 || r_index !== 4'd9 || r_pfn !== 20'hABCDE) begin
      errors++; $display("FAIL tlbwi_resp got %b %0d %h exp 1 9 ABCDE", r_found, r_index, r_pfn);
    end
    next();
  endtask

  task automatic test_flush();
    logic [2:0] g;
    logic [2:0] exp_g [5] = '{3'b001, 3'b100, 3'b000, 3'b010, 3'b001};
    i_req = 1'b1; i_vpn2 = 19'h00010; i_odd = 1'b1;
    for (int t = 0; t < 5; t++) begin
      half();
      g = {p_gnt, d_gnt, i_gnt};
      checks++;
      if (g !== exp_g[t]) begin errors++; $display("FAIL flush_gnt t %0d got %b exp %b", t, g, exp_g[t]); end
      case (t)
        0: push(REQ_I, 1'b0);
        1: push(REQ_P, 1'b1);
        3: push(REQ_D, 1'b1);
        4: push(REQ_I, 1'b1);
        default: ;
      endcase
      next();
      case (t)
        0: begin i_req = 1'b0; flush = 1'b1; d_req = 1'b1; d_vpn2 = 19'h00102; p_req = 1'b1; p_vpn2 = 19'h00107; end
        1: begin p_req = 1'b0; i_req = 1'b1; end
        2: flush = 1'b0;
        3: d_req = 1'b0;
        default: i_req = 1'b0;
      endcase
    end
    half();
    next();
  endtask

  task automatic test_reset_mid();
    logic [2:0] g;
    i_req = 1'b1; i_vpn2 = 19'h00010; i_odd = 1'b0;
    half();
    push(REQ_I, 1'b0);
    next();
    reset = 1'b1;
    half();
    g = {p_gnt, d_gnt, i_gnt};
    checks++;
    if (g !== 3'b000) begin errors++; $display("FAIL rstmid_gnt got %b exp 000", g); end
    next();
    reset = 1'b0;
    half();
    g = {p_gnt, d_gnt, i_gnt};
    checks++;
    if ({r_found, r_index, r_pfn, r_c, r_d, r_v} !== 30'd0 || dut.starve_cnt_q !== 2'd0) begin
      errors++; $display("FAIL rstmid_clear resp %h cnt %0d exp 0 0", {r_found, r_index, r_pfn, r_c, r_d, r_v}, dut.starve_cnt_q);
    end
    checks++;
    if (g !== 3'b001) begin errors++; $display("FAIL rstmid_regnt got %b exp 001", g); end
    push(REQ_I, 1'b1);
    next();
    i_req = 1'b0;
    half();
    next();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    cyc = 0; checks = 0; errors = 0;
    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; p_req = 1'b0;
    i_vpn2 = '0; d_vpn2 = '0; p_vpn2 = '0; i_odd = 1'b0; d_odd = 1'b0;
    asid = 8'h05; tlbwi_we = 1'b0; flush = 1'b0;
    for (int k = 0; k < 16; k++) begin
      logic [3:0] kk;
      kk = 4'(k);
      e_vpn2[k] = (k == 5) ? 19'h00010 : 19'h00100 + 19'(k);
      e_asid[k] = 8'h05;
      e_g[k]    = (k == 7);
      e_pg[k][0] = {20'h10000 + 20'(2 * k), kk[2:0], kk[0], 1'b1};
      e_pg[k][1] = {20'h20000 + 20'(2 * k + 1), ~kk[2:0], ~kk[0], kk[1]};
    end
    #1;
    test_reset();
    test_single();
    test_all_three();
    test_starve();
    test_tlbwi();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
